accumulator_drain_unit: RTL and testbench

- Downstream of the accumulator control unit.
- On its done pulse, streams finished rows out of the accumulator memory.
- Per lane: optional ReLU, then rounding right-shift requantisation and saturation to 8 bit.
- Writes each row to the unified buffer with ready/valid backpressure; one row per cycle at full throughput.

---
 rtl/accumulator_drain_unit.sv | 153 +++++++++++++++
 tb/tb_accumulator_drain_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_drain_unit.sv
// accumulator_drain_unit
//   Streams finished rows out of the accumulator memory after the accumulator
//   control unit signals done. Each 32-bit lane goes through optional ReLU,
//   a round-half-up arithmetic right shift and saturation to 8 bits. The
//   quantised row is written to the unified buffer under ready/valid flow
//   control, one row per cycle when the buffer never stalls.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-low reset
//   start_i                 one-cycle start pulse, accepted only when idle
//   acc_base_i, num_rows_i  first accumulator row and row count (0 = no-op)
//   ub_base_i               first unified-buffer destination row
//   shift_i, relu_en_i      requantisation shift (0..31) and ReLU enable
//   acc_rd_en_o/_addr_o     accumulator read port, data returns next cycle
//   acc_rd_data_i           returned row, lane 0 in the LSBs
//   ub_wr_en_o/_addr_o/_data_o, ub_ready_i   unified-buffer write handshake
//   busy_o, done_o          drain in progress / one-cycle completion pulse
module accumulator_drain_unit #(
   parameter int MUL_SIZE = 32,
   parameter int ACC_W    = 32,
   parameter int OUT_W    = 8,
   parameter int ADDR_W   = 10
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [ADDR_W-1:0]         acc_base_i,
   input  logic [ADDR_W-1:0]         num_rows_i,
   input  logic [ADDR_W-1:0]         ub_base_i,
   input  logic [4:0]                shift_i,
   input  logic                      relu_en_i,
   output logic                      acc_rd_en_o,
   output logic [ADDR_W-1:0]         acc_rd_addr_o,
   input  logic [MUL_SIZE*ACC_W-1:0] acc_rd_data_i,
   output logic                      ub_wr_en_o,
   input  logic                      ub_ready_i,
   output logic [ADDR_W-1:0]         ub_wr_addr_o,
   output logic [MUL_SIZE*OUT_W-1:0] ub_wr_data_o,
   output logic                      busy_o,
   output logic                      done_o
);
   localparam int ROW_W = MUL_SIZE * OUT_W;
   localparam logic [ADDR_W-1:0]     ONE    = ADDR_W'(1);
   localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] acc_base_q, num_rows_q, ub_base_q, rd_cnt_q, wr_cnt_q;
   logic [4:0]        shift_q;
   logic              relu_q, inflight_q, done_q;
   logic [1:0]        fifo_cnt_q, fifo_cnt_d;
   logic [ROW_W-1:0]  fifo_q [2];
   logic [ROW_W-1:0]  q_row;
   logic              rd_en, push, pop;

   // One lane: widened by one bit so the rounding add cannot overflow.
   function automatic logic [OUT_W-1:0] quant(input logic [ACC_W-1:0] x,
                                              input logic [4:0] sh,
                                              input logic relu);
      logic signed [ACC_W:0] xe, rnd, y, lo;
      xe = $signed({x[ACC_W-1], x});
      if (relu && x[ACC_W-1]) xe = '0;
      rnd = '0;
      if (sh != 5'd0) rnd = {{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1);
      y  = (xe + rnd) >>> sh;
      lo = relu ? '0 : SAT_LO;
      if (y > SAT_HI)  quant = SAT_HI[OUT_W-1:0];
      else if (y < lo) quant = lo[OUT_W-1:0];
      else             quant = y[OUT_W-1:0];
   endfunction

   always_comb begin
      q_row = '0;
      for (int l = 0; l < MUL_SIZE; l++)
         q_row[l*OUT_W +: OUT_W] = quant(acc_rd_data_i[l*ACC_W +: ACC_W], shift_q, relu_q);
   end

   // Read data is valid the cycle after the strobe, so push follows it.
   assign push = inflight_q;
   assign pop  = (fifo_cnt_q != 2'd0) && ub_ready_i;

   // Credit: rows in flight plus rows queued, less the one leaving now, must
   // leave room in the 2-entry FIFO for the read being issued.
   assign rd_en = (state_q == DRAIN) && (rd_cnt_q < num_rows_q) &&
                  (({2'b00, inflight_q} + {1'b0, fifo_cnt_q}) < (3'd2 + {2'b00, pop}));

   assign fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         acc_base_q <= '0;
         num_rows_q <= '0;
         ub_base_q  <= '0;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         fifo_cnt_q <= '0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= rd_en;
         fifo_cnt_q <= fifo_cnt_d;

         // Head lives in slot 0; a pop shifts slot 1 down unless a push on a
         // single-entry FIFO replaces the head directly.
         if (pop) fifo_q[0] <= (push && fifo_cnt_q == 2'd1) ? q_row : fifo_q[1];
         else if (push) fifo_q[fifo_cnt_q[0]] <= q_row;

         if (rd_en) rd_cnt_q <= rd_cnt_q + ONE;
         if (pop)   wr_cnt_q <= wr_cnt_q + ONE;

         case (state_q)
            IDLE: if (start_i) begin
               acc_base_q <= acc_base_i;
               num_rows_q <= num_rows_i;
               ub_base_q  <= ub_base_i;
               shift_q    <= shift_i;
               relu_q     <= relu_en_i;
               rd_cnt_q   <= '0;
               wr_cnt_q   <= '0;
               if (num_rows_i == '0) done_q  <= 1'b1;
               else                  state_q <= DRAIN;
            end
            DRAIN: if (rd_en && (rd_cnt_q + ONE) == num_rows_q) state_q <= FLUSH;
            FLUSH: if (pop && (wr_cnt_q + ONE) == num_rows_q) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) assert (!(push && fifo_cnt_q == 2'd2));
   end

   assign acc_rd_en_o   = rd_en;
   assign acc_rd_addr_o = rd_en ? acc_base_q + rd_cnt_q : '0;
   assign ub_wr_en_o    = (fifo_cnt_q != 2'd0);
   assign ub_wr_addr_o  = ub_wr_en_o ? ub_base_q + wr_cnt_q : '0;
   assign ub_wr_data_o  = ub_wr_en_o ? fifo_q[0] : '0;
   assign busy_o        = (state_q != IDLE);
   assign done_o        = done_q;

endmodule

// File: tb/tb_accumulator_drain_unit.sv
module tb_accumulator_drain_unit;
   localparam int MS = 32, AW = 32, OW = 8, ADW = 10;

   logic              clk_i = 1'b0;
   logic              rst_i, start_i, relu_en_i, ub_ready_i;
   logic [ADW-1:0]    acc_base_i, num_rows_i, ub_base_i;
   logic [4:0]        shift_i;
   logic              acc_rd_en_o, ub_wr_en_o, busy_o, done_o;
   logic [ADW-1:0]    acc_rd_addr_o, ub_wr_addr_o;
   logic [MS*AW-1:0]  acc_rd_data_i;
   logic [MS*OW-1:0]  ub_wr_data_o;

   always #5 clk_i = ~clk_i;

   accumulator_drain_unit #(.MUL_SIZE(MS), .ACC_W(AW), .OUT_W(OW), .ADDR_W(ADW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .acc_base_i(acc_base_i), .num_rows_i(num_rows_i), .ub_base_i(ub_base_i),
      .shift_i(shift_i), .relu_en_i(relu_en_i),
      .acc_rd_en_o(acc_rd_en_o), .acc_rd_addr_o(acc_rd_addr_o), .acc_rd_data_i(acc_rd_data_i),
      .ub_wr_en_o(ub_wr_en_o), .ub_ready_i(ub_ready_i), .ub_wr_addr_o(ub_wr_addr_o),
      .ub_wr_data_o(ub_wr_data_o), .busy_o(busy_o), .done_o(done_o)
   );

   // Accumulator memory model with one-cycle read latency.
   logic [MS*AW-1:0] mem [1024];
   always @(posedge clk_i) begin
      if (acc_rd_en_o) acc_rd_data_i <= mem[acc_rd_addr_o];
      else             acc_rd_data_i <= {32{32'hDEADBEEF}};
   end

   int n_checks = 0, n_fail = 0;

   // Observations gathered by drain().
   logic [ADW-1:0]   rd_addrs[$], obs_addr[$];
   logic [MS*OW-1:0] obs_data[$];
   int first_rd, first_wr, done_off, done_cnt, busy_err, unstable, max_pend;
   int issued, xfers, extra, rdaddr_err;

   // Reference quantiser in plain integer arithmetic.
   function automatic logic [7:0] ref_q(input logic signed [31:0] v, input int sh, input bit relu);
      longint x, y;
      x = v;
      if (relu && x < 0) x = 0;
      if (sh > 0) y = (x + (64'sd1 << (sh - 1))) >>> sh;
      else        y = x;
      if (y > 127) y = 127;
      if (relu && y < 0) y = 0;
      if (y < -128) y = -128;
      return y[7:0];
   endfunction

   function automatic logic [MS*OW-1:0] exp_row(input logic [ADW-1:0] a, input int sh, input bit relu);
      logic [MS*OW-1:0] r;
      for (int l = 0; l < MS; l++) r[l*8 +: 8] = ref_q(mem[a][l*32 +: 32], sh, relu);
      return r;
   endfunction

   task automatic fill_rows(input logic [ADW-1:0] a, input int n);
      for (int r = 0; r < n; r++)
         for (int l = 0; l < MS; l++)
            mem[a + ADW'(r)][l*32 +: 32] = ($urandom_range(0, 3) == 0) ? $urandom
                                          : 32'($urandom_range(0, 4000)) - 32'd2000;
   endtask

   // Starts one drain and records what the DUT does, cycle by cycle.
   // Offset 1 is the cycle right after the accepting edge.
   task automatic drain(input logic [ADW-1:0] ab, input logic [ADW-1:0] nr, input logic [ADW-1:0] ub,
                        input logic [4:0] sh, input bit relu, input int stall_after, input int stall_len,
                        input bit rand_rdy, input int restart_at, input int stop_at);
      bit prev_stall = 0;
      logic [ADW-1:0] prev_addr = '0;
      logic [MS*OW-1:0] prev_data = '0;
      int stalled = 0;
      rd_addrs.delete(); obs_addr.delete(); obs_data.delete();
      first_rd = -1; first_wr = -1; done_off = -1; done_cnt = 0; busy_err = 0; unstable = 0;
      max_pend = 0; issued = 0; xfers = 0; extra = 0; rdaddr_err = 0;
      @(negedge clk_i);
      start_i = 1; acc_base_i = ab; num_rows_i = nr; ub_base_i = ub; shift_i = sh; relu_en_i = relu;
      ub_ready_i = 1;
      for (int off = 1; off <= 300; off++) begin
         @(negedge clk_i);
         start_i    = (off == restart_at);
         acc_base_i = ADW'($urandom); num_rows_i = ADW'($urandom_range(1, 20));
         ub_base_i  = ADW'($urandom); shift_i = 5'($urandom); relu_en_i = 1'($urandom);
         if (rand_rdy) ub_ready_i = ($urandom_range(0, 3) != 0);
         else if (xfers == stall_after && stalled < stall_len) begin ub_ready_i = 0; stalled++; end
         else ub_ready_i = 1;
         #1;
         if (done_o) begin done_cnt++; done_off = off; end
         if ((done_cnt == 0) !== busy_o) busy_err++;
         if (done_cnt > 0 && !done_o && (acc_rd_en_o || ub_wr_en_o)) extra++;
         if (acc_rd_en_o) begin
            rd_addrs.push_back(acc_rd_addr_o); issued++;
            if (first_rd < 0) first_rd = off;
         end else if (acc_rd_addr_o !== '0) rdaddr_err++;
         if (ub_wr_en_o && first_wr < 0) first_wr = off;
         if (prev_stall && (!ub_wr_en_o || ub_wr_addr_o !== prev_addr || ub_wr_data_o !== prev_data))
            unstable++;
         prev_stall = ub_wr_en_o && !ub_ready_i;
         prev_addr = ub_wr_addr_o; prev_data = ub_wr_data_o;
         if (ub_wr_en_o && ub_ready_i) begin
            obs_addr.push_back(ub_wr_addr_o); obs_data.push_back(ub_wr_data_o); xfers++;
         end
         if (issued - xfers > max_pend) max_pend = issued - xfers;
         if (off == stop_at) break;
         if (done_cnt > 0 && off >= done_off + 3) break;
      end
      start_i = 0; ub_ready_i = 1;
   endtask

   task automatic test_reset;
      rst_i = 0; start_i = 0; relu_en_i = 0; ub_ready_i = 1; acc_base_i = '0; num_rows_i = '0;
      ub_base_i = '0; shift_i = '0;
      repeat (3) @(negedge clk_i);
      n_checks++;
      if ({acc_rd_en_o, ub_wr_en_o, busy_o, done_o} !== 4'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {acc_rd_en_o, ub_wr_en_o, busy_o, done_o});
      end
      n_checks++;
      if (acc_rd_addr_o !== '0 || ub_wr_addr_o !== '0 || ub_wr_data_o !== '0) begin
         n_fail++; $display("FAIL reset_bus: rd_addr %0d wr_addr %0d expected 0", acc_rd_addr_o, ub_wr_addr_o);
      end
      rst_i = 1;
      repeat (2) @(negedge clk_i);
      n_checks++;
      if ({busy_o, done_o, acc_rd_en_o} !== 3'b0) begin
         n_fail++; $display("FAIL post_reset_idle: got %b expected 000", {busy_o, done_o, acc_rd_en_o});
      end
   endtask

   task automatic test_basic;
      int v0 [4] = '{100, 300, -5, -300};
      logic [7:0] e0 [4] = '{8'd100, 8'd127, 8'hFB, 8'h80};
      logic [ADW-1:0] ub = ADW'($urandom_range(0, 1000));
      fill_rows(0, 4);
      for (int r = 0; r < 4; r++) mem[r][31:0] = v0[r];
      drain(0, 4, ub, 0, 0, -1, 0, 0, -1, -1);
      n_checks++;
      if (obs_data.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", obs_data.size()); end
      for (int i = 0; i < obs_data.size() && i < 4; i++) begin
         n_checks++;
         if (obs_data[i][7:0] !== e0[i]) begin
            n_fail++; $display("FAIL basic_lane0 row%0d: got %0d expected %0d", i, obs_data[i][7:0], e0[i]);
         end
         n_checks++;
         if (obs_data[i] !== exp_row(ADW'(i), 0, 0) || obs_addr[i] !== ub + ADW'(i)) begin
            n_fail++; $display("FAIL basic_row%0d: addr %0d expected %0d", i, obs_addr[i], ub + ADW'(i));
         end
      end
      n_checks++;
      if (first_rd != 1 || first_wr != 3) begin
         n_fail++; $display("FAIL basic_latency: rd %0d wr %0d expected 1 3", first_rd, first_wr);
      end
      n_checks++;
      if (done_off != 7 || done_cnt != 1) begin
         n_fail++; $display("FAIL basic_done: at %0d count %0d expected 7 1", done_off, done_cnt);
      end
      n_checks++;
      if (busy_err != 0 || rdaddr_err != 0) begin
         n_fail++; $display("FAIL basic_busy_addr: busy errs %0d rd_addr errs %0d expected 0", busy_err, rdaddr_err);
      end
   endtask

   task automatic test_quant;
      mem[100] = '0;
      mem[100][31:0] = 32'd6; mem[100][63:32] = -32'sd6; mem[100][95:64] = 32'h7FFFFFFF;
      drain(100, 1, 5, 2, 0, -1, 0, 0, -1, -1);
      n_checks++;
      if (obs_data.size() != 1 || obs_data[0][7:0] !== 8'd2 || obs_data[0][15:8] !== 8'hFF) begin
         n_fail++; $display("FAIL quant_shift2: got %0d %0d expected 2 -1", obs_data[0][7:0], $signed(obs_data[0][15:8]));
      end
      drain(100, 1, 5, 2, 1, -1, 0, 0, -1, -1);
      n_checks++;
      if (obs_data.size() != 1 || obs_data[0][7:0] !== 8'd2 || obs_data[0][15:8] !== 8'd0) begin
         n_fail++; $display("FAIL quant_relu: got %0d %0d expected 2 0", obs_data[0][7:0], obs_data[0][15:8]);
      end
      drain(100, 1, 5, 31, 0, -1, 0, 0, -1, -1);
      n_checks++;
      if (obs_data.size() != 1 || obs_data[0][23:16] !== 8'd1) begin
         n_fail++; $display("FAIL quant_shift31: got %0d expected 1", obs_data[0][23:16]);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 8; it++) begin
         logic [ADW-1:0] ab = ADW'($urandom), ub = ADW'($urandom);
         int n = $urandom_range(1, 6), sh = $urandom_range(0, 31);
         bit relu = 1'($urandom);
         fill_rows(ab, n);
         drain(ab, ADW'(n), ub, 5'(sh), relu, -1, 0, 1, -1, -1);
         n_checks++;
         if (obs_data.size() != n || done_cnt != 1) begin
            n_fail++; $display("FAIL rand%0d_count: rows %0d dones %0d expected %0d 1", it, obs_data.size(), done_cnt, n);
         end
         for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_row(ab + ADW'(i), sh, relu) || obs_addr[i] !== ub + ADW'(i)) begin
               n_fail++; $display("FAIL rand%0d_row%0d: addr %0d data %h expected addr %0d data %h", it, i,
                                  obs_addr[i], obs_data[i], ub + ADW'(i), exp_row(ab + ADW'(i), sh, relu));
            end
         end
         n_checks++;
         if (unstable != 0 || max_pend > 2 || busy_err != 0) begin
            n_fail++; $display("FAIL rand%0d_flow: unstable %0d pending %0d busy errs %0d expected 0 <=2 0",
                               it, unstable, max_pend, busy_err);
         end
      end
   endtask

   task automatic test_backpressure;
      fill_rows(400, 8);
      drain(400, 8, 77, 3, 0, 1, 5, 0, -1, -1);
      n_checks++;
      if (obs_data.size() != 8 || done_cnt != 1) begin
         n_fail++; $display("FAIL bp_count: rows %0d dones %0d expected 8 1", obs_data.size(), done_cnt);
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_data[i] !== exp_row(ADW'(400 + i), 3, 0) || obs_addr[i] !== ADW'(77 + i)) begin
            n_fail++; $display("FAIL bp_row%0d: addr %0d expected %0d", i, obs_addr[i], 77 + i);
         end
      end
      n_checks++;
      if (unstable != 0 || max_pend > 2) begin
         n_fail++; $display("FAIL bp_stall: unstable %0d pending %0d expected 0 <=2", unstable, max_pend);
      end
      n_checks++;
      if (done_off != 16) begin n_fail++; $display("FAIL bp_done: at %0d expected 16", done_off); end
   endtask

   task automatic test_wrap;
      logic [ADW-1:0] ea [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
      logic [ADW-1:0] eu [4] = '{10'd1021, 10'd1022, 10'd1023, 10'd0};
      fill_rows(1022, 4);
      drain(1022, 4, 1021, 4, 1, -1, 0, 0, -1, -1);
      n_checks++;
      if (rd_addrs.size() != 4 || obs_data.size() != 4) begin
         n_fail++; $display("FAIL wrap_count: reads %0d rows %0d expected 4 4", rd_addrs.size(), obs_data.size());
      end
      for (int i = 0; i < 4 && i < rd_addrs.size() && i < obs_data.size(); i++) begin
         n_checks++;
         if (rd_addrs[i] !== ea[i] || obs_addr[i] !== eu[i] || obs_data[i] !== exp_row(ea[i], 4, 1)) begin
            n_fail++; $display("FAIL wrap_%0d: rd %0d wr %0d expected %0d %0d", i, rd_addrs[i], obs_addr[i], ea[i], eu[i]);
         end
      end
   endtask

   task automatic test_zero_restart;
      drain(12, 0, 34, 0, 0, -1, 0, 0, -1, -1);
      n_checks++;
      if (done_off != 1 || done_cnt != 1 || busy_err != 0) begin
         n_fail++; $display("FAIL zero_done: at %0d count %0d busy errs %0d expected 1 1 0", done_off, done_cnt, busy_err);
      end
      n_checks++;
      if (rd_addrs.size() != 0 || first_wr != -1) begin
         n_fail++; $display("FAIL zero_traffic: reads %0d first write %0d expected 0 -1", rd_addrs.size(), first_wr);
      end
      fill_rows(50, 6);
      drain(50, 6, 200, 3, 0, -1, 0, 0, 3, -1);
      n_checks++;
      if (obs_data.size() != 6 || done_cnt != 1 || done_off != 9 || extra != 0) begin
         n_fail++; $display("FAIL restart_ignored: rows %0d dones %0d at %0d extra %0d expected 6 1 9 0",
                            obs_data.size(), done_cnt, done_off, extra);
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_data[i] !== exp_row(ADW'(50 + i), 3, 0) || obs_addr[i] !== ADW'(200 + i)) begin
            n_fail++; $display("FAIL restart_row%0d: addr %0d expected %0d", i, obs_addr[i], 200 + i);
         end
      end
   endtask

   task automatic test_reset_mid;
      int bad = 0;
      fill_rows(300, 8);
      drain(300, 8, 10, 4, 1, -1, 0, 0, -1, 5);
      n_checks++;
      if (obs_data.size() != 3) begin n_fail++; $display("FAIL rmid_pre: rows %0d expected 3", obs_data.size()); end
      @(negedge clk_i);
      rst_i = 0;
      #1;
      n_checks++;
      if ({acc_rd_en_o, ub_wr_en_o, busy_o, done_o} !== 4'b0 || acc_rd_addr_o !== '0 ||
          ub_wr_addr_o !== '0 || ub_wr_data_o !== '0) begin
         n_fail++; $display("FAIL rmid_async: ctrl %b rd_addr %0d wr_addr %0d expected 0",
                            {acc_rd_en_o, ub_wr_en_o, busy_o, done_o}, acc_rd_addr_o, ub_wr_addr_o);
      end
      repeat (3) begin @(negedge clk_i); if (done_o || busy_o || ub_wr_en_o) bad++; end
      rst_i = 1;
      @(negedge clk_i); if (done_o || busy_o) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL rmid_quiet: %0d active cycles expected 0", bad); end
      fill_rows(600, 8);
      drain(600, 8, 900, 1, 0, -1, 0, 0, -1, -1);
      n_checks++;
      if (obs_data.size() != 8 || done_cnt != 1 || done_off != 11) begin
         n_fail++; $display("FAIL rmid_redrain: rows %0d dones %0d at %0d expected 8 1 11",
                            obs_data.size(), done_cnt, done_off);
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_data[i] !== exp_row(ADW'(600 + i), 1, 0) || obs_addr[i] !== ADW'(900 + i)) begin
            n_fail++; $display("FAIL rmid_row%0d: addr %0d expected %0d", i, obs_addr[i], 900 + i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_quant();
      test_random();
      test_backpressure();
      test_wrap();
      test_zero_restart();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
